// File: rtl/an_encoder_24bits_clk.sv
`default_nettype none
// ============================================================================
// Module   : an_encoder_24bits_clk
// Purpose  : Clocked AN-code encoder. Computes W = A*N with a serial
//            shift-and-add multiplier (one multiplier bit per cycle) and can
//            add a single +/-2^k arithmetic error for decoder testing.
// Revision : 1.0 - initial release
// ============================================================================
module an_encoder_24bits_clk #(
   parameter int A      = 67,
   parameter int A_BITS = 7,
   parameter int N_BITS = 24,
   parameter int W_BITS = 32,
   parameter int P_BITS = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_BITS-1:0] N,
   input  logic              err_en,
   input  logic              err_neg,
   input  logic [P_BITS-1:0] err_pos,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W_BITS-1:0] W,
   output logic              err_flag
);

   localparam int CNT_BITS = (A_BITS > 1) ? $clog2(A_BITS) : 1;

   localparam logic [A_BITS-1:0]   c_a        = A_BITS'(A);
   localparam logic [CNT_BITS-1:0] c_cnt_last = CNT_BITS'(A_BITS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_INJ  = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   logic [1:0]          r_state;
   logic [1:0]          w_next_state;

   logic [W_BITS-1:0]   r_nreg;
   logic [W_BITS-1:0]   r_acc;
   logic [CNT_BITS-1:0] r_cnt;
   logic                r_err_en;
   logic                r_err_neg;
   logic [P_BITS-1:0]   r_err_pos;
   logic [W_BITS-1:0]   r_w;
   logic                r_err_flag;
   logic                r_out_valid;

   logic                w_accept;
   logic                w_mul_step;
   logic                w_inj;
   logic                w_release;
   logic [W_BITS-1:0]   w_partial;
   logic [W_BITS-1:0]   w_err_mag;
   logic [W_BITS-1:0]   w_err_term;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: MUL runs exactly A_BITS steps, HOLD waits for out_ready
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)             w_next_state = S_MUL;
         S_MUL:   if (r_cnt == c_cnt_last)  w_next_state = S_INJ;
         S_INJ:                             w_next_state = S_HOLD;
         S_HOLD:  if (out_ready)            w_next_state = S_IDLE;
         default:                           w_next_state = S_IDLE;
      endcase
   end

   // Output/control decode from the current state only
   always_comb begin
      in_ready   = (r_state == S_IDLE);
      w_accept   = (r_state == S_IDLE) && in_valid;
      w_mul_step = (r_state == S_MUL);
      w_inj      = (r_state == S_INJ);
      w_release  = (r_state == S_HOLD) && out_ready;
   end

   // Partial product for the current multiplier bit and the signed error term
   always_comb begin
      w_partial  = c_a[r_cnt] ? (r_nreg << r_cnt) : '0;
      w_err_mag  = {{(W_BITS-1){1'b0}}, 1'b1} << r_err_pos;
      w_err_term = '0;
      if (r_err_en) begin
         w_err_term = r_err_neg ? (~w_err_mag + 1'b1) : w_err_mag;
      end
   end

   // Datapath: capture at accept, accumulate in MUL, inject and publish in INJ
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_nreg      <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_err_en    <= 1'b0;
         r_err_neg   <= 1'b0;
         r_err_pos   <= '0;
         r_w         <= '0;
         r_err_flag  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_nreg    <= W_BITS'(N);
            r_err_en  <= err_en;
            r_err_neg <= err_neg;
            r_err_pos <= err_pos;
            r_acc     <= '0;
            r_cnt     <= '0;
         end
         if (w_mul_step) begin
            r_acc <= r_acc + w_partial;
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_inj) begin
            r_w         <= r_acc + w_err_term;
            r_err_flag  <= r_err_en;
            r_out_valid <= 1'b1;
         end
         if (w_release) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign W         = r_w;
   assign err_flag  = r_err_flag;
   assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_an_encoder_24bits_clk.sv
`default_nettype none
// ============================================================================
// Module   : tb_an_encoder_24bits_clk
// Purpose  : Self-checking bench for an_encoder_24bits_clk: directed corner
//            words, stall/ignore behaviour, mid-word reset and random words
//            compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_an_encoder_24bits_clk;

   localparam int c_a      = 67;
   localparam int c_w_bits = 32;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] n_in;
   logic        err_en;
   logic        err_neg;
   logic [4:0]  err_pos;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] w_out;
   logic        err_flag;

   int n_tests;
   int n_fail;

   an_encoder_24bits_clk #(
      .A      (67),
      .A_BITS (7),
      .N_BITS (24),
      .W_BITS (32),
      .P_BITS (5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .N         (n_in),
      .err_en    (err_en),
      .err_neg   (err_neg),
      .err_pos   (err_pos),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .W         (w_out),
      .err_flag  (err_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop so a wedged DUT can never hang the run
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached (got stuck, required finish)");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic, reduced modulo 2^32
   function automatic logic [31:0] model(input longint n, input bit en, input bit neg,
                                         input int pos);
      longint v;
      v = c_a * n;
      if (en) v = neg ? (v - (64'sd1 <<< pos)) : (v + (64'sd1 <<< pos));
      return v[c_w_bits-1:0];
   endfunction

   // Send one word, check latency/result, stall for hold_cyc cycles, release
   task automatic run_word(input logic [23:0] n, input bit en, input bit neg,
                           input logic [4:0] pos, input int hold_cyc, input bit poke);
      logic [31:0] exp_w;
      logic [31:0] held_w;
      int          lat;
      int          waited;
      exp_w  = model(longint'(n), en, neg, int'(pos));
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      n_in     = n;
      err_en   = en;
      err_neg  = neg;
      err_pos  = pos;
      @(negedge clk);
      // Scramble inputs after accept: the word in flight must not change
      in_valid = 1'b0;
      n_in     = 24'($urandom);
      err_en   = 1'($urandom);
      err_neg  = 1'($urandom);
      err_pos  = 5'($urandom);
      check("in_ready_busy", 64'(in_ready), 64'd0);
      lat = 0;
      while (!out_valid && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 64'(lat), 64'd8);
      check("W", 64'(w_out), 64'(exp_w));
      check("err_flag", 64'(err_flag), 64'(en));
      held_w = w_out;
      for (int h = 0; h < hold_cyc; h++) begin
         if (poke && h == 0) begin
            in_valid = 1'b1;
            n_in     = 24'd5;
         end
         @(negedge clk);
         in_valid = 1'b0;
         check("hold_W", 64'(w_out), 64'(held_w));
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("released_valid", 64'(out_valid), 64'd0);
      check("released_ready", 64'(in_ready), 64'd1);
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      n_in      = '0;
      err_en    = 1'b0;
      err_neg   = 1'b0;
      err_pos   = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_W", 64'(w_out), 64'd0);
      check("rst_err_flag", 64'(err_flag), 64'd0);
      rst_n = 1'b1;

      // Directed words
      run_word(24'd1,        1'b0, 1'b0, 5'd0,  0, 1'b0);
      check("W_eq_67", 64'(w_out), 64'h43);
      run_word(24'hFFFFFF,   1'b0, 1'b0, 5'd0,  0, 1'b0);
      check("W_max", 64'(w_out), 64'h42FFFFBD);
      run_word(24'd100,      1'b1, 1'b0, 5'd3,  0, 1'b0);
      check("W_plus8", 64'(w_out), 64'd6708);
      run_word(24'd100,      1'b1, 1'b1, 5'd0,  0, 1'b0);
      check("W_minus1", 64'(w_out), 64'd6699);
      run_word(24'd0,        1'b1, 1'b1, 5'd0,  0, 1'b0);
      check("W_wrap_neg", 64'(w_out), 64'hFFFFFFFF);
      run_word(24'hFFFFFF,   1'b1, 1'b0, 5'd31, 0, 1'b0);
      check("W_wrap_pos", 64'(w_out), 64'hC2FFFFBD);

      // Stall five cycles with an ignored in_valid pulse, then N=5
      run_word(24'd9,        1'b0, 1'b0, 5'd0,  5, 1'b1);
      run_word(24'd5,        1'b0, 1'b0, 5'd0,  0, 1'b0);
      check("W_335", 64'(w_out), 64'd335);

      // Reset in the middle of MUL for N=7
      @(negedge clk);
      in_valid = 1'b1;
      n_in     = 24'd7;
      err_en   = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 64'(out_valid), 64'd0);
      check("midrst_W", 64'(w_out), 64'd0);
      check("midrst_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("postrst_valid", 64'(out_valid), 64'd0);
      check("postrst_W", 64'(w_out), 64'd0);
      check("postrst_ready", 64'(in_ready), 64'd1);
      run_word(24'd2,        1'b0, 1'b0, 5'd0,  0, 1'b0);
      check("W_134", 64'(w_out), 64'd134);

      // Random words with random stalls
      for (int i = 0; i < 40; i++) begin
         run_word(24'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                  int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
